serial_word_collector: RTL and testbench

//  Receive end of the shift-register datapath: collects a serial bit stream into WIDTH-bit words.

---
 rtl/serial_word_collector.sv | 127 ++++++++++++
 tb/tb_serial_word_collector.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector with a one-entry valid/ready output buffer.
// Optional feature macro: PARITY_CHECK_EN (trailing even-parity bit per word).
module serial_word_collector #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             dir,
   output logic [WIDTH-1:0] op,
   output logic             op_valid,
   input  logic             op_ready,
   output logic             par_err,
   output logic             overflow,
   input  logic             overflow_clr,
   output logic             busy
);
`ifdef PARITY_CHECK_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d, sr_sh, word;
   logic [WIDTH-1:0] op_q, op_d;
   logic             dir_q, dir_d, dir_use;
   logic             op_valid_q, op_valid_d;
   logic             ovf_q, ovf_d;
   logic             busy_q;
   logic             done;
`ifdef PARITY_CHECK_EN
   localparam logic [CNT_W-1:0] PAR_POS = CNT_W'(WIDTH);
   logic             par_q, par_d, par_bit;
`endif

   // The first bit of a word follows the live dir input; later bits use the latched order.
   assign dir_use = (cnt_q == '0) ? dir : dir_q;
   assign sr_sh   = dir_use ? {sin, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], sin};

   always_comb begin
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      dir_d      = dir_q;
      op_d       = op_q;
      op_valid_d = op_valid_q;
      ovf_d      = ovf_q;
      done       = 1'b0;
      word       = sr_sh;
`ifdef PARITY_CHECK_EN
      par_d      = par_q;
      par_bit    = (^sr_q) ^ sin;
      word       = sr_q;
`endif
      if (sin_valid) begin
         if (cnt_q == '0) dir_d = dir;
`ifdef PARITY_CHECK_EN
         // The parity bit only feeds the check; sr already holds the full data word.
         if (cnt_q != PAR_POS) sr_d = sr_sh;
`else
         sr_d = sr_sh;
`endif
         if (cnt_q == LAST) begin
            cnt_d = '0;
            done  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (done) begin
         if (!op_valid_q || op_ready) begin
            op_d       = word;
            op_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
            par_d      = par_bit;
`endif
         end else begin
            ovf_d = 1'b1;
         end
      end else if (op_valid_q && op_ready) begin
         op_valid_d = 1'b0;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (overflow_clr && !(done && op_valid_q && !op_ready)) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         sr_q       <= '0;
         dir_q      <= 1'b0;
         op_q       <= '0;
         op_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
`ifdef PARITY_CHECK_EN
         par_q      <= 1'b0;
`endif
      end else begin
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         dir_q      <= dir_d;
         op_q       <= op_d;
         op_valid_q <= op_valid_d;
         ovf_q      <= ovf_d;
         busy_q     <= (cnt_d != '0);
`ifdef PARITY_CHECK_EN
         par_q      <= par_d;
`endif
      end
   end

   assign op       = op_q;
   assign op_valid = op_valid_q;
   assign overflow = ovf_q;
   assign busy     = busy_q;
`ifdef PARITY_CHECK_EN
   assign par_err  = par_q;
`else
   assign par_err  = 1'b0;
`endif
endmodule

// File: tb/tb_serial_word_collector.sv
// Randomized + directed bench for serial_word_collector against a bit-queue reference model.
module tb_serial_word_collector;
   localparam int W = 4;
`ifdef PARITY_CHECK_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif

   logic clk = 1'b0;
   logic rst, sin, sin_valid, dir, op_ready, overflow_clr;
   logic [W-1:0] op;
   logic op_valid, par_err, overflow, busy;
   int total = 0;
   int bad = 0;

   // reference model state
   logic         bq[$];
   logic         m_dir;
   logic [W-1:0] m_op;
   logic         m_vld, m_par, m_ovf;

   serial_word_collector #(.WIDTH(W), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .dir(dir),
      .op(op), .op_valid(op_valid), .op_ready(op_ready), .par_err(par_err),
      .overflow(overflow), .overflow_clr(overflow_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance the model by the same cycle, sample #1 after the edge.
   task automatic step(input logic v, input logic s, input logic d, input logic r,
                       input logic c, input logic x);
      logic [W-1:0] w;
      logic p, done, set;
      sin_valid = v; sin = s; dir = d; op_ready = r; overflow_clr = c; rst = x;
      w = '0; p = 1'b0; done = 1'b0; set = 1'b0;
      if (x) begin
         bq.delete(); m_dir = 1'b0; m_op = '0; m_vld = 1'b0; m_par = 1'b0; m_ovf = 1'b0;
      end else begin
         if (v) begin
            if (bq.size() == 0) m_dir = d;
            bq.push_back(s);
            if (bq.size() == NB) begin
               for (int i = 0; i < W; i++) begin
                  if (!m_dir) w[W-1-i] = bq[i];
                  else        w[i]     = bq[i];
               end
`ifdef PARITY_CHECK_EN
               for (int i = 0; i < NB; i++) p = p ^ bq[i];
`endif
               done = 1'b1;
               bq.delete();
            end
         end
         if (done) begin
            if (!m_vld || r) begin m_op = w; m_vld = 1'b1; m_par = p; end
            else set = 1'b1;
         end else if (m_vld && r) m_vld = 1'b0;
         if (set) m_ovf = 1'b1;
         else if (c) m_ovf = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input logic r, input logic c);
      step(1'b0, 1'b0, 1'b0, r, c, 1'b0);
   endtask

   // Send tx[W-1] first; dir alternates after the first bit to exercise latching.
   task automatic send_word(input logic [W-1:0] tx, input logic d, input logic rl, input logic cl);
      for (int i = 0; i < W; i++) begin
         if (NB == W && i == W-1) step(1'b1, tx[W-1-i], d ^ i[0], rl, cl, 1'b0);
         else                     step(1'b1, tx[W-1-i], d ^ i[0], 1'b0, 1'b0, 1'b0);
      end
      if (NB != W) step(1'b1, ^tx, ~d, rl, cl, 1'b0);
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if ({op, op_valid, par_err, overflow, busy} !== 8'h00) begin
         bad++; $display("FAIL reset: got op=%b vld=%b par=%b ovf=%b busy=%b want all 0",
                         op, op_valid, par_err, overflow, busy);
      end
   endtask

   task automatic test_msb();
      send_word(4'b1100, 1'b0, 1'b0, 1'b0);
      total++;
      if ({op, op_valid, busy, par_err} !== {4'b1100, 1'b1, 1'b0, 1'b0}) begin
         bad++; $display("FAIL msb: got op=%b vld=%b busy=%b par=%b want 1100 1 0 0",
                         op, op_valid, busy, par_err);
      end
   endtask

   task automatic test_lsb_latched();
      idle(1'b1, 1'b0);
      total++;
      if (op_valid !== 1'b0) begin bad++; $display("FAIL drain: vld=%b want 0", op_valid); end
      send_word(4'b0011, 1'b1, 1'b0, 1'b0);
      total++;
      if ({op, op_valid} !== {4'b1100, 1'b1}) begin
         bad++; $display("FAIL lsb_latched: got op=%b vld=%b want 1100 1", op, op_valid);
      end
   endtask

   task automatic test_overflow();
      idle(1'b1, 1'b1);
      send_word(4'b1010, 1'b0, 1'b0, 1'b0);
      send_word(4'b0101, 1'b0, 1'b0, 1'b0);
      total++;
      if ({op, op_valid, overflow} !== {4'b1010, 1'b1, 1'b1}) begin
         bad++; $display("FAIL overflow_set: got op=%b vld=%b ovf=%b want 1010 1 1", op, op_valid, overflow);
      end
      send_word(4'b1111, 1'b0, 1'b0, 1'b1);
      total++;
      if ({op, overflow} !== {4'b1010, 1'b1}) begin
         bad++; $display("FAIL overflow_set_wins: got op=%b ovf=%b want 1010 1", op, overflow);
      end
      idle(1'b0, 1'b1);
      total++;
      if ({overflow, op_valid} !== 2'b01) begin
         bad++; $display("FAIL overflow_clr: got ovf=%b vld=%b want 0 1", overflow, op_valid);
      end
   endtask

   task automatic test_back_to_back();
      idle(1'b1, 1'b0);
      send_word(4'b1001, 1'b0, 1'b1, 1'b0);
      total++;
      if ({op, op_valid} !== {4'b1001, 1'b1}) begin
         bad++; $display("FAIL b2b_first: got op=%b vld=%b want 1001 1", op, op_valid);
      end
      send_word(4'b0110, 1'b0, 1'b1, 1'b0);
      total++;
      if ({op, op_valid, overflow} !== {4'b0110, 1'b1, 1'b0}) begin
         bad++; $display("FAIL b2b_second: got op=%b vld=%b ovf=%b want 0110 1 0", op, op_valid, overflow);
      end
   endtask

   task automatic test_reset_midword();
      logic [3:0] tx;
      tx = 4'b1010;
      idle(1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_partial: got %b want 1", busy); end
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      total++;
      if ({op, op_valid, par_err, overflow, busy} !== 8'h00) begin
         bad++; $display("FAIL reset_mid: got op=%b vld=%b par=%b ovf=%b busy=%b want all 0",
                         op, op_valid, par_err, overflow, busy);
      end
      for (int i = 0; i < W; i++) begin
         step(1'b1, tx[W-1-i], 1'b0, 1'b0, 1'b0, 1'b0);
         step(1'b0, ~tx[W-1-i], 1'b1, 1'b0, 1'b0, 1'b0);
      end
      if (NB != W) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if ({op, op_valid, busy} !== {4'b1010, 1'b1, 1'b0}) begin
         bad++; $display("FAIL gaps: got op=%b vld=%b busy=%b want 1010 1 0", op, op_valid, busy);
      end
   endtask

   task automatic test_parity();
      logic [4:0] a, b;
      idle(1'b1, 1'b1);
`ifdef PARITY_CHECK_EN
      a = 5'b11001; b = 5'b11000;
      for (int i = 0; i < 5; i++) step(1'b1, a[4-i], 1'b0, (i == 4), 1'b0, 1'b0);
      total++;
      if ({op, par_err, op_valid} !== {4'b1100, 1'b1, 1'b1}) begin
         bad++; $display("FAIL parity_bad: got op=%b par=%b vld=%b want 1100 1 1", op, par_err, op_valid);
      end
      for (int i = 0; i < 5; i++) step(1'b1, b[4-i], 1'b0, (i == 4), 1'b0, 1'b0);
      total++;
      if ({op, par_err} !== {4'b1100, 1'b0}) begin
         bad++; $display("FAIL parity_ok: got op=%b par=%b want 1100 0", op, par_err);
      end
`else
      a = 5'b01100; b = 5'b00000;
      for (int i = 0; i < 4; i++) step(1'b1, a[3-i], b[0], (i == 3), 1'b0, 1'b0);
      total++;
      if ({op, par_err, op_valid} !== {4'b1100, 1'b0, 1'b1}) begin
         bad++; $display("FAIL parity_off: got op=%b par=%b vld=%b want 1100 0 1", op, par_err, op_valid);
      end
`endif
   endtask

   task automatic test_random();
      logic [W+3:0] got, exp;
      for (int n = 0; n < 800; n++) begin
         step(($urandom_range(0, 9) < 7), $urandom_range(0, 1), $urandom_range(0, 1),
              ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 1), ($urandom_range(0, 59) == 0));
         got = {op, op_valid, par_err, overflow, busy};
         exp = {m_op, m_vld, m_par, m_ovf, (bq.size() != 0)};
         total++;
         if (got !== exp) begin
            bad++; $display("FAIL random cyc=%0d: got {op,vld,par,ovf,busy}=%b want %b", n, got, exp);
         end
      end
   endtask

   initial begin
      rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; dir = 1'b0; op_ready = 1'b0; overflow_clr = 1'b0;
      test_reset();
      test_msb();
      test_lsb_latched();
      test_overflow();
      test_back_to_back();
      test_reset_midword();
      test_parity();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
